// File: rtl/pdua_pkg.sv
// pdua_pkg: shared definitions for the PDUA hardwired control unit.
// Holds opcode and ALU-operation encodings, register-bank addresses,
// the sequencer state encoding and the packed control-word layout.
package pdua_pkg;

    localparam int OPC_W      = 5;
    localparam int REG_ADDR_W = 3;

    // Instruction opcodes
    localparam logic [OPC_W-1:0] OPC_NOP       = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_MOV_ACC_K = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_MOV_ACC_A = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_MOV_A_ACC = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_ADD_ACC_A = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_NOT_ACC   = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_JZ        = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SHL_ACC   = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_HALT      = 5'b11111;

    // ALU operation select
    localparam logic [2:0] SEL_PASS = 3'b000;
    localparam logic [2:0] SEL_ADD  = 3'b001;
    localparam logic [2:0] SEL_SUB  = 3'b010;
    localparam logic [2:0] SEL_AND  = 3'b011;
    localparam logic [2:0] SEL_OR   = 3'b100;
    localparam logic [2:0] SEL_NOT  = 3'b101;
    localparam logic [2:0] SEL_INC  = 3'b110;
    localparam logic [2:0] SEL_SHL  = 3'b111;

    // Register-bank addresses
    localparam logic [REG_ADDR_W-1:0] REG_PC  = 3'b000;
    localparam logic [REG_ADDR_W-1:0] REG_A   = 3'b001;
    localparam logic [REG_ADDR_W-1:0] REG_ACC = 3'b111;

    typedef enum logic [3:0] {
        S_F_ADDR  = 4'd0,
        S_F_READ  = 4'd1,
        S_F_IR    = 4'd2,
        S_DECODE  = 4'd3,
        S_E_ADDR  = 4'd4,
        S_E_READ  = 4'd5,
        S_E_LDACC = 4'd6,
        S_E_ALU   = 4'd7,
        S_E_JMP   = 4'd8,
        S_HALT    = 4'd9
    } state_e;

    typedef struct packed {
        logic                  wr_rdn;
        logic                  enaf;
        logic [2:0]            selop;
        logic [1:0]            shamt;
        logic                  bank_wr_en;
        logic [REG_ADDR_W-1:0] busb_addr;
        logic [REG_ADDR_W-1:0] busc_addr;
        logic                  sclr;
        logic                  ir_en;
        logic                  mar_en;
        logic                  mdr_en;
        logic                  mdr_alu_n;
        logic                  halted;
    } ctrl_word_t;

    // Opcodes that complete in a single ALU execute cycle
    function automatic logic is_alu_op(input logic [OPC_W-1:0] opc);
        logic hit;
        case (opc)
            OPC_MOV_ACC_A,
            OPC_MOV_A_ACC,
            OPC_ADD_ACC_A,
            OPC_NOT_ACC,
            OPC_SHL_ACC: hit = 1'b1;
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pdua_ctrl_decode.sv
// pdua_ctrl_decode: combinational map from sequencer state, latched opcode
// and the Z flag to the full datapath control word.
// Ports:
//   state_i  - current sequencer state
//   opcode_i - opcode latched at DECODE (meaningful in execute states)
//   z_i      - ALU zero flag, only consulted in E_JMP
//   cw_o     - control word; every field not driven by a state is 0
module pdua_ctrl_decode
    import pdua_pkg::*;
(
    input  state_e                 state_i,
    input  logic [OPC_W-1:0]       opcode_i,
    input  logic                   z_i,
    output ctrl_word_t             cw_o
);

    // Per-state control pattern
    always_comb begin
        cw_o = '0;
        case (state_i)
            S_F_ADDR, S_E_ADDR: begin
                cw_o.busb_addr = REG_PC;
                cw_o.mar_en    = 1'b1;
            end
            // Memory read of the byte at PC while PC is incremented.
            S_F_READ, S_E_READ: begin
                cw_o.wr_rdn     = 1'b0;
                cw_o.mdr_en     = 1'b1;
                cw_o.selop      = SEL_INC;
                cw_o.busb_addr  = REG_PC;
                cw_o.bank_wr_en = 1'b1;
                cw_o.busc_addr  = REG_PC;
            end
            S_F_IR: begin
                cw_o.ir_en     = 1'b1;
                cw_o.mdr_alu_n = 1'b1;
            end
            S_DECODE: begin
                cw_o = '0;
            end
            S_E_LDACC: begin
                cw_o.mdr_alu_n  = 1'b1;
                cw_o.bank_wr_en = 1'b1;
                cw_o.busc_addr  = REG_ACC;
            end
            S_E_ALU: begin
                cw_o.bank_wr_en = 1'b1;
                cw_o.busc_addr  = REG_ACC;
                case (opcode_i)
                    OPC_MOV_ACC_A: begin
                        cw_o.busb_addr = REG_A;
                        cw_o.selop     = SEL_PASS;
                    end
                    OPC_MOV_A_ACC: begin
                        cw_o.busb_addr = REG_ACC;
                        cw_o.selop     = SEL_PASS;
                        cw_o.busc_addr = REG_A;
                    end
                    OPC_ADD_ACC_A: begin
                        cw_o.busb_addr = REG_A;
                        cw_o.selop     = SEL_ADD;
                        cw_o.enaf      = 1'b1;
                    end
                    OPC_NOT_ACC: begin
                        cw_o.busb_addr = REG_ACC;
                        cw_o.selop     = SEL_NOT;
                        cw_o.enaf      = 1'b1;
                    end
                    OPC_SHL_ACC: begin
                        cw_o.busb_addr = REG_ACC;
                        cw_o.selop     = SEL_SHL;
                        cw_o.shamt     = 2'b01;
                        cw_o.enaf      = 1'b1;
                    end
                    // Unreachable for legal sequencing; keep the bank safe.
                    default: begin
                        cw_o = '0;
                    end
                endcase
            end
            // Jump target is already in MDR; load PC only when Z is set.
            S_E_JMP: begin
                if (z_i) begin
                    cw_o.mdr_alu_n  = 1'b1;
                    cw_o.bank_wr_en = 1'b1;
                    cw_o.busc_addr  = REG_PC;
                end else begin
                    cw_o = '0;
                end
            end
            S_HALT: begin
                cw_o.halted = 1'b1;
            end
            default: begin
                cw_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/pdua_control_unit.sv
// pdua_control_unit: hardwired fetch/decode/execute sequencer for the PDUA
// datapath. Holds the state register and latched opcode; control lines are
// a combinational decode of the registered state (plus Z in E_JMP).
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   out_IR              - opcode from the datapath IR, valid in DECODE
//   C, N, P, Z          - ALU flags (only Z is used, in E_JMP)
//   wr_rdn .. mdr_alu_n - datapath control lines
//   halted              - high while the sequencer is stopped in HALT
module pdua_control_unit
    import pdua_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int OPC_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPC_WIDTH-1:0]  out_IR,
    input  logic                  C,
    input  logic                  N,
    input  logic                  P,
    input  logic                  Z,
    output logic                  wr_rdn,
    output logic                  enaf,
    output logic [2:0]            selop,
    output logic [1:0]            shamt,
    output logic                  bank_wr_en,
    output logic [ADDR_WIDTH-1:0] BusB_addr,
    output logic [ADDR_WIDTH-1:0] BusC_addr,
    output logic                  sclr,
    output logic                  ir_en,
    output logic                  mar_en,
    output logic                  mdr_en,
    output logic                  mdr_alu_n,
    output logic                  halted
);

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    logic [OPC_W-1:0] opcode_in_s;
    logic             z_eff_s;
    ctrl_word_t       cw_s;

    assign opcode_in_s = OPC_W'(out_IR);

    // C/N/P are reserved for future branches; they are referenced here so
    // they remain wired through, but the AND with zero removes any effect.
    assign z_eff_s = Z | (1'b0 & (C ^ N ^ P));

    // State and opcode registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_F_ADDR;
            opcode_q <= OPC_NOP;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Next-state logic; opcode is captured in DECODE so later execute
    // cycles do not depend on out_IR staying stable.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            S_F_ADDR: state_d = S_F_READ;
            S_F_READ: state_d = S_F_IR;
            S_F_IR:   state_d = S_DECODE;
            S_DECODE: begin
                opcode_d = opcode_in_s;
                if (opcode_in_s == OPC_NOP) begin
                    state_d = S_F_ADDR;
                end else if ((opcode_in_s == OPC_MOV_ACC_K) || (opcode_in_s == OPC_JZ)) begin
                    state_d = S_E_ADDR;
                end else if (is_alu_op(opcode_in_s)) begin
                    state_d = S_E_ALU;
                end else begin
                    state_d = S_HALT;
                end
            end
            S_E_ADDR: state_d = S_E_READ;
            S_E_READ: begin
                if (opcode_q == OPC_MOV_ACC_K) begin
                    state_d = S_E_LDACC;
                end else begin
                    state_d = S_E_JMP;
                end
            end
            S_E_LDACC: state_d = S_F_ADDR;
            S_E_ALU:   state_d = S_F_ADDR;
            S_E_JMP:   state_d = S_F_ADDR;
            S_HALT:    state_d = S_HALT;
            // Corrupted state encoding: park the sequencer.
            default:   state_d = S_HALT;
        endcase
    end

    pdua_ctrl_decode u_decode (
        .state_i  (state_q),
        .opcode_i (opcode_q),
        .z_i      (z_eff_s),
        .cw_o     (cw_s)
    );

    // Output drive; reset forces only the datapath clear.
    always_comb begin
        if (rst) begin
            wr_rdn     = 1'b0;
            enaf       = 1'b0;
            selop      = 3'b000;
            shamt      = 2'b00;
            bank_wr_en = 1'b0;
            BusB_addr  = '0;
            BusC_addr  = '0;
            sclr       = 1'b1;
            ir_en      = 1'b0;
            mar_en     = 1'b0;
            mdr_en     = 1'b0;
            mdr_alu_n  = 1'b0;
            halted     = 1'b0;
        end else begin
            wr_rdn     = cw_s.wr_rdn;
            enaf       = cw_s.enaf;
            selop      = cw_s.selop;
            shamt      = cw_s.shamt;
            bank_wr_en = cw_s.bank_wr_en;
            BusB_addr  = ADDR_WIDTH'(cw_s.busb_addr);
            BusC_addr  = ADDR_WIDTH'(cw_s.busc_addr);
            sclr       = cw_s.sclr;
            ir_en      = cw_s.ir_en;
            mar_en     = cw_s.mar_en;
            mdr_en     = cw_s.mdr_en;
            mdr_alu_n  = cw_s.mdr_alu_n;
            halted     = cw_s.halted;
        end
    end

endmodule

// File: tb/tb_pdua_control_unit.sv
// Directed testbench for pdua_control_unit. All outputs are packed into one
// 20-bit vector {wr_rdn, enaf, selop, shamt, bank_wr_en, BusB, BusC, sclr,
// ir_en, mar_en, mdr_en, mdr_alu_n, halted} and compared per cycle against
// hand-written expected words.
module tb_pdua_control_unit;

    logic       clk;
    logic       rst;
    logic [4:0] out_IR;
    logic       C, N, P, Z;
    logic       wr_rdn, enaf, bank_wr_en, sclr, ir_en, mar_en, mdr_en, mdr_alu_n, halted;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic [2:0] BusB_addr, BusC_addr;

    int n_cmp;
    int n_err;

    //                                wr    enaf  selop   shamt bwe   busb    busc    sclr  ir    mar   mdr   m_a   hlt
    localparam logic [19:0] W_RST   = {1'b0,1'b0,3'b000,2'b00,1'b0,3'b000,3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] W_FADDR = {1'b0,1'b0,3'b000,2'b00,1'b0,3'b000,3'b000,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
    localparam logic [19:0] W_FREAD = {1'b0,1'b0,3'b110,2'b00,1'b1,3'b000,3'b000,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
    localparam logic [19:0] W_FIR   = {1'b0,1'b0,3'b000,2'b00,1'b0,3'b000,3'b000,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};
    localparam logic [19:0] W_IDLE  = {1'b0,1'b0,3'b000,2'b00,1'b0,3'b000,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] W_LDACC = {1'b0,1'b0,3'b000,2'b00,1'b1,3'b000,3'b111,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
    localparam logic [19:0] W_MACCA = {1'b0,1'b0,3'b000,2'b00,1'b1,3'b001,3'b111,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] W_MAACC = {1'b0,1'b0,3'b000,2'b00,1'b1,3'b111,3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] W_ADD   = {1'b0,1'b1,3'b001,2'b00,1'b1,3'b001,3'b111,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] W_NOT   = {1'b0,1'b1,3'b101,2'b00,1'b1,3'b111,3'b111,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] W_SHL   = {1'b0,1'b1,3'b111,2'b01,1'b1,3'b111,3'b111,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [19:0] W_JMP1  = {1'b0,1'b0,3'b000,2'b00,1'b1,3'b000,3'b000,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
    localparam logic [19:0] W_HALT  = {1'b0,1'b0,3'b000,2'b00,1'b0,3'b000,3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};

    logic [19:0] obs;
    assign obs = {wr_rdn, enaf, selop, shamt, bank_wr_en, BusB_addr, BusC_addr,
                  sclr, ir_en, mar_en, mdr_en, mdr_alu_n, halted};

    pdua_control_unit #(.ADDR_WIDTH(3), .OPC_WIDTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .out_IR     (out_IR),
        .C          (C),
        .N          (N),
        .P          (P),
        .Z          (Z),
        .wr_rdn     (wr_rdn),
        .enaf       (enaf),
        .selop      (selop),
        .shamt      (shamt),
        .bank_wr_en (bank_wr_en),
        .BusB_addr  (BusB_addr),
        .BusC_addr  (BusC_addr),
        .sclr       (sclr),
        .ir_en      (ir_en),
        .mar_en     (mar_en),
        .mdr_en     (mdr_en),
        .mdr_alu_n  (mdr_alu_n),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the four fetch/decode cycles, presenting opc to the IR.
    // Starts in F_ADDR; ends just after the DECODE edge.
    task automatic fetch_decode(input string tag, input logic [4:0] opc);
        check_eq({tag, "_faddr"}, obs, W_FADDR);
        step();
        check_eq({tag, "_fread"}, obs, W_FREAD);
        step();
        check_eq({tag, "_fir"}, obs, W_FIR);
        out_IR = opc;
        step();
        check_eq({tag, "_decode"}, obs, W_IDLE);
        step();
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        out_IR = 5'b00000;
        C = 1'b0; N = 1'b0; P = 1'b0; Z = 1'b0;

        // Reset held for two cycles
        step();
        check_eq("rst_c1", obs, W_RST);
        step();
        check_eq("rst_c2", obs, W_RST);
        rst = 1'b0;
        #1;

        // NOP: four-cycle loop back to F_ADDR
        fetch_decode("nop", 5'b00000);

        // MOV ACC,#k: 7 cycles, ends in E_LDACC
        fetch_decode("movk", 5'b00001);
        check_eq("movk_eaddr", obs, W_FADDR);
        step();
        check_eq("movk_eread", obs, W_FREAD);
        step();
        check_eq("movk_ldacc", obs, W_LDACC);
        step();

        // ADD ACC,A; IR changes after DECODE must not matter
        fetch_decode("add", 5'b00100);
        out_IR = 5'b00000;
        #1;
        check_eq("add_ealu", obs, W_ADD);
        step();

        fetch_decode("macca", 5'b00010);
        check_eq("macca_ealu", obs, W_MACCA);
        step();

        fetch_decode("maacc", 5'b00011);
        check_eq("maacc_ealu", obs, W_MAACC);
        step();

        // NOT with Z/C/N/P set: flags must not affect ALU ops
        Z = 1'b1; C = 1'b1; N = 1'b1; P = 1'b1;
        fetch_decode("not", 5'b00101);
        check_eq("not_ealu", obs, W_NOT);
        step();
        Z = 1'b0; C = 1'b0; N = 1'b0; P = 1'b0;

        fetch_decode("shl", 5'b00111);
        check_eq("shl_ealu", obs, W_SHL);
        step();

        // JZ taken
        fetch_decode("jz1", 5'b00110);
        check_eq("jz1_eaddr", obs, W_FADDR);
        step();
        check_eq("jz1_eread", obs, W_FREAD);
        step();
        Z = 1'b1;
        #1;
        check_eq("jz1_ejmp", obs, W_JMP1);
        step();

        // JZ not taken (C/N/P set to show they are ignored)
        Z = 1'b0; C = 1'b1; N = 1'b1; P = 1'b1;
        fetch_decode("jz0", 5'b00110);
        check_eq("jz0_eaddr", obs, W_FADDR);
        step();
        check_eq("jz0_eread", obs, W_FREAD);
        step();
        check_eq("jz0_ejmp", obs, W_IDLE);
        step();
        C = 1'b0; N = 1'b0; P = 1'b0;

        // Undefined opcode -> HALT, sticky for many cycles
        fetch_decode("undef", 5'b01010);
        for (int i = 0; i < 12; i++) begin
            Z = i[0];
            out_IR = 5'(i);
            #1;
            check_eq($sformatf("halt_%0d", i), obs, W_HALT);
            step();
        end

        // Reset out of HALT
        rst = 1'b1;
        #1;
        check_eq("halt_rst", obs, W_RST);
        step();
        rst = 1'b0;
        #1;

        // Explicit HALT opcode
        fetch_decode("hlt", 5'b11111);
        check_eq("hlt_state", obs, W_HALT);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;

        // Reset during JZ E_READ aborts the instruction
        Z = 1'b1;
        fetch_decode("jzr", 5'b00110);
        check_eq("jzr_eaddr", obs, W_FADDR);
        step();
        check_eq("jzr_eread", obs, W_FREAD);
        rst = 1'b1;
        #1;
        check_eq("jzr_rst", obs, W_RST);
        step();
        rst = 1'b0;
        #1;
        check_eq("jzr_after", obs, W_FADDR);
        step();
        check_eq("jzr_fread", obs, W_FREAD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
